rpn_eval: RTL

Postfix (RPN) expression evaluator. It consumes the ASCII token stream produced by the `onp` infix-to-RPN converter and evaluates it on an internal operand stack. When it sees `=`, it emits the signed decimal result as ASCII characters on a second byte stream. It sits directly downstream of `onp`, using the same strobe/acknowledge byte handshake on both sides.

---
 rtl/rpn_pkg.sv | 41 ++++
 rtl/rpn_divider.sv | 74 +++++++
 rtl/rpn_eval.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rpn_pkg                                                              |
// | Shared ASCII constants, FSM state and error-cause types for rpn_eval |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rpn_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;
  localparam logic [7:0] CH_EQU   = 8'h3D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_E     = 8'h45;

  typedef enum logic [1:0] {
    S_IN   = 2'd0,
    S_DIV  = 2'd1,
    S_CONV = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_UNDERFLOW    = 3'd1,
    ERR_OVERFLOW     = 3'd2,
    ERR_DIV_ZERO     = 3'd3,
    ERR_DEPTH        = 3'd4,
    ERR_DIV_DISABLED = 3'd5
  } err_t;

  // ceil(w * log10(2)) using a fixed-point log10(2) = 0.30103
  function automatic int calc_ndig(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rpn_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rpn_divider                                                          |
// | Iterative unsigned restoring divider, WIDTH cycles, start/done       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rpn_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   w_shift, w_trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    w_shift = {rem_q, quo_q[WIDTH-1]};
    w_trial = w_shift - {1'b0, dvs_q};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      // Remainder stays below the divisor, so bit WIDTH of the trial is the borrow
      if (!w_trial[WIDTH]) begin
        rem_d = w_trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = w_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: rtl/rpn_eval.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rpn_eval                                                             |
// | RPN evaluator: ASCII token stream in, signed decimal result out.     |
// | Define RPN_EVAL_DIV_EN to enable the '/' operator.                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rpn_eval
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_stb,
  input  logic [7:0] in_char,
  output logic       in_ack,
  output logic       out_stb,
  output logic [7:0] out_char,
  input  logic       out_ack
);
  localparam int NDIG = calc_ndig(WIDTH);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW   = $clog2(DEPTH + 1);
  localparam int DW   = $clog2(NDIG + 1);
  localparam int DIW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state_q, state_d;
  err_t             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [SW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pending_q, pending_d;
  logic             div_neg_q, div_neg_d;
  logic             sign_q, sign_d;
  logic [3:0]       dig_q [NDIG];
  logic [3:0]       dig_d [NDIG];
  logic [DW-1:0]    ndig_q, ndig_d, left_q, left_d;
  logic             out_stb_q, out_stb_d;
  logic [7:0]       out_char_q, out_char_d;

  logic             div_start, div_done;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quo, div_rem;

  logic             w_xfer_in, w_is_digit, w_is_op, w_full, w_under, w_eq_ok, w_div_go;
  logic [SW-1:0]    w_cnt;
  logic [AW-1:0]    w_i1, w_i2, w_slot;
  logic [WIDTH-1:0] w_a, w_b, w_res, w_abs_a, w_abs_b, w_q_fix;
  logic [3:0]       w_digit;

  rpn_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Operand view with any pending literal treated as already pushed
  always_comb begin
    w_xfer_in  = in_stb && (state_q == S_IN);
    w_is_digit = (in_char >= CH_0) && (in_char <= CH_0 + 8'd9);
    w_is_op    = (in_char == CH_PLUS) || (in_char == CH_MINUS) || (in_char == CH_MUL);
    w_i1       = AW'(sp_q - SW'(1));
    w_i2       = AW'(sp_q - SW'(2));
    w_full     = pending_q && (sp_q == SW'(DEPTH));
    w_cnt      = sp_q + SW'(pending_q);
    w_under    = (w_cnt < SW'(2));
    w_b        = pending_q ? acc_q : stack_q[w_i1];
    w_a        = pending_q ? stack_q[w_i1] : stack_q[w_i2];
    w_slot     = pending_q ? w_i1 : w_i2;
    w_abs_a    = w_a[WIDTH-1] ? -w_a : w_a;
    w_abs_b    = w_b[WIDTH-1] ? -w_b : w_b;
    w_eq_ok    = (err_q == ERR_NONE) && !w_full && (w_cnt == SW'(1));
    w_q_fix    = div_neg_q ? -div_quo : div_quo;
    w_digit    = (div_rem < WIDTH'(10)) ? div_rem[3:0] : 4'd9;
    w_res      = w_a + w_b;
    if (in_char == CH_MINUS)
      w_res = w_a - w_b;
    else if (in_char == CH_MUL)
      w_res = w_a * w_b;
  end

`ifdef RPN_EVAL_DIV_EN
  assign w_div_go = w_xfer_in && (in_char == CH_DIV) && (err_q == ERR_NONE) &&
                    !w_full && !w_under && (w_b != '0);
`else
  assign w_div_go = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IN: begin
        if (w_xfer_in && (in_char == CH_EQU))
          state_d = w_eq_ok ? S_CONV : S_OUT;
        else if (w_div_go)
          state_d = S_DIV;
      end
      S_DIV:   if (div_done) state_d = S_IN;
      S_CONV:  if (div_done && (div_quo == '0)) state_d = S_OUT;
      default: if (out_stb_q && out_ack && (out_char_q == CH_LF)) state_d = S_IN;
    endcase
  end

  always_comb begin
    err_d        = err_q;
    stack_d      = stack_q;
    sp_d         = sp_q;
    acc_d        = acc_q;
    pending_d    = pending_q;
    div_neg_d    = div_neg_q;
    sign_d       = sign_q;
    dig_d        = dig_q;
    ndig_d       = ndig_q;
    left_d       = left_q;
    out_stb_d    = out_stb_q;
    out_char_d   = out_char_q;
    div_start    = 1'b0;
    div_dividend = div_quo;
    div_divisor  = WIDTH'(10);
    case (state_q)
      S_IN: begin
        if (w_xfer_in && (in_char == CH_EQU)) begin
          acc_d     = '0;
          pending_d = 1'b0;
          if (w_eq_ok) begin
            div_start    = 1'b1;
            div_dividend = w_abs_b;
            sign_d       = w_b[WIDTH-1];
            ndig_d       = '0;
            sp_d         = '0;
          end else begin
            out_stb_d  = 1'b1;
            out_char_d = CH_E;
            sign_d     = 1'b0;
            left_d     = '0;
            if (err_q == ERR_NONE)
              err_d = w_full ? ERR_OVERFLOW : ERR_DEPTH;
          end
        end else if (w_xfer_in && (err_q == ERR_NONE)) begin
          if (w_is_digit) begin
            acc_d     = acc_q * WIDTH'(10) + WIDTH'(in_char[3:0]);
            pending_d = 1'b1;
          end else if (in_char == CH_SPACE) begin
            if (pending_q) begin
              if (w_full) begin
                err_d = ERR_OVERFLOW;
              end else begin
                stack_d[AW'(sp_q)] = acc_q;
                sp_d               = sp_q + SW'(1);
              end
              acc_d     = '0;
              pending_d = 1'b0;
            end
          end else if (w_is_op) begin
            acc_d     = '0;
            pending_d = 1'b0;
            if (w_full)
              err_d = ERR_OVERFLOW;
            else if (w_under)
              err_d = ERR_UNDERFLOW;
            else begin
              stack_d[w_slot] = w_res;
              sp_d            = w_cnt - SW'(1);
            end
          end else if (in_char == CH_DIV) begin
`ifdef RPN_EVAL_DIV_EN
            acc_d     = '0;
            pending_d = 1'b0;
            if (w_full)
              err_d = ERR_OVERFLOW;
            else if (w_under)
              err_d = ERR_UNDERFLOW;
            else if (w_b == '0)
              err_d = ERR_DIV_ZERO;
            else begin
              // Magnitudes go to the divider; the sign is restored on completion
              div_start    = 1'b1;
              div_dividend = w_abs_a;
              div_divisor  = w_abs_b;
              div_neg_d    = w_a[WIDTH-1] ^ w_b[WIDTH-1];
              sp_d         = w_cnt - SW'(2);
            end
`else
            err_d = ERR_DIV_DISABLED;
`endif
          end
        end
      end
      S_DIV: begin
        if (div_done) begin
          stack_d[AW'(sp_q)] = w_q_fix;
          sp_d               = sp_q + SW'(1);
        end
      end
      S_CONV: begin
        if (div_done) begin
          dig_d[DIW'(ndig_q)] = w_digit;
          ndig_d              = ndig_q + DW'(1);
          if (div_quo != '0)
            div_start = 1'b1;
          else
            left_d = ndig_q + DW'(1);
        end
      end
      default: begin
        // out_stb_q low here only on entry from conversion: load the first character
        if (!out_stb_q || out_ack) begin
          if (out_stb_q && (out_char_q == CH_LF)) begin
            out_stb_d = 1'b0;
            sp_d      = '0;
            acc_d     = '0;
            pending_d = 1'b0;
            err_d     = ERR_NONE;
          end else begin
            out_stb_d = 1'b1;
            if (sign_q) begin
              out_char_d = CH_MINUS;
              sign_d     = 1'b0;
            end else if (left_q != '0) begin
              out_char_d = CH_0 + {4'b0000, dig_q[DIW'(left_q - DW'(1))]};
              left_d     = left_q - DW'(1);
            end else begin
              out_char_d = CH_LF;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IN;
      err_q      <= ERR_NONE;
      sp_q       <= '0;
      acc_q      <= '0;
      pending_q  <= 1'b0;
      div_neg_q  <= 1'b0;
      sign_q     <= 1'b0;
      ndig_q     <= '0;
      left_q     <= '0;
      out_stb_q  <= 1'b0;
      out_char_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      sp_q       <= sp_d;
      acc_q      <= acc_d;
      pending_q  <= pending_d;
      div_neg_q  <= div_neg_d;
      sign_q     <= sign_d;
      ndig_q     <= ndig_d;
      left_q     <= left_d;
      out_stb_q  <= out_stb_d;
      out_char_q <= out_char_d;
    end
  end

  // Storage arrays need no reset: sp_q and ndig_q/left_q qualify every read
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
    dig_q   <= dig_d;
  end

  always_comb begin
    in_ack   = (state_q == S_IN);
    out_stb  = out_stb_q;
    out_char = out_char_q;
  end

endmodule
`default_nettype wire
